// File: rtl/aes_key_schedule.sv
`timescale 1ns/1ps
// AES key-schedule engine: accepts a 128/192/256-bit key via valid/ready,
// expands one 32-bit schedule word per cycle into a round-key buffer that
// consumers can read by index while expansion is still in progress.
module aes_key_schedule #(
    parameter int unsigned RK_DEPTH = 16,
    parameter int unsigned AW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [255:0]  key,
    input  logic [1:0]    key_len,
    input  logic [AW:0]   num_rk,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   rk_avail,
    input  logic [AW-1:0] rd_addr,
    output logic [127:0]  rd_data
);

    localparam int unsigned IW = AW + 3;

    // AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    typedef enum logic {IDLE, GEN} state_t;

    state_t         state_q, state_d;
    logic [3:0]     nk_q, nk_d, nk_in;
    logic [AW:0]    nrk_q, nrk_d, nrk_in;
    logic [IW-1:0]  i_q, i_d, wc_q, wc_d;
    logic [2:0]     pos_q, pos_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [AW:0]    avail_q, avail_d, avail_wc;
    logic           done_q, done_d;
    logic [127:0]   rd_q;
    logic [31:0]    win_q [8];
    logic [31:0]    win_d [8];
    logic [31:0]    keyw  [8];
    logic [31:0]    prev_w, old_w, tmp_w, new_w;
    logic           load, gen_we;
    logic [AW-1:0]  widx;
    logic [127:0]   buf_q [RK_DEPTH];

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q == GEN);
    assign done      = done_q;
    assign rk_avail  = avail_q;
    assign rd_data   = rd_q;
    assign widx      = i_q[AW+1:2];

    // Decode key length, clamp the round-key count, split the key into words.
    always_comb begin
        unique case (key_len)
            2'd0:    nk_in = 4'd4;
            2'd1:    nk_in = 4'd6;
            default: nk_in = 4'd8;
        endcase
        if (num_rk < (AW+1)'(2))
            nrk_in = (AW+1)'(2);
        else if (num_rk > (AW+1)'(RK_DEPTH))
            nrk_in = (AW+1)'(RK_DEPTH);
        else
            nrk_in = num_rk;
        for (int unsigned m = 0; m < 8; m++)
            keyw[m] = key[(7 - m) * 32 +: 32];
    end

    // Next schedule word from the sliding window (win_q[0] = w[i-1]).
    always_comb begin
        prev_w = win_q[0];
        old_w  = win_q[3'(nk_q - 4'd1)];
        if (pos_q == 3'd0)
            tmp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && pos_q == 3'd4)
            tmp_w = sub_word(prev_w);
        else
            tmp_w = prev_w;
        new_w = old_w ^ tmp_w;
        avail_wc = (wc_q[IW-1:2] < nrk_q) ? wc_q[IW-1:2] : nrk_q;
    end

    // Next-state, counters and window update.
    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nrk_d   = nrk_q;
        i_d     = i_q;
        wc_d    = wc_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        avail_d = avail_wc;
        done_d  = (avail_wc == nrk_q) && (avail_q != nrk_q);
        load    = 1'b0;
        gen_we  = 1'b0;
        for (int unsigned j = 0; j < 8; j++)
            win_d[j] = win_q[j];
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    load    = 1'b1;
                    nk_d    = nk_in;
                    nrk_d   = nrk_in;
                    i_d     = IW'(nk_in);
                    wc_d    = IW'(nk_in);
                    pos_d   = '0;
                    rcon_d  = 8'h01;
                    avail_d = '0;
                    for (int unsigned j = 0; j < 8; j++)
                        if (j < 32'(nk_in))
                            win_d[j] = keyw[3'(32'(nk_in) - 32'd1 - j)];
                    // 256-bit key with two round keys is complete at load time.
                    if ({nrk_in, 2'b00} > IW'(nk_in))
                        state_d = GEN;
                end
            end
            GEN: begin
                if (abort) begin
                    state_d = IDLE;
                    wc_d    = '0;
                    avail_d = '0;
                    done_d  = 1'b0;
                end else begin
                    gen_we = 1'b1;
                    i_d    = i_q + IW'(1);
                    wc_d   = i_q + IW'(1);
                    for (int unsigned j = 1; j < 8; j++)
                        win_d[j] = win_q[j-1];
                    win_d[0] = new_w;
                    if (4'(pos_q) + 4'd1 == nk_q) begin
                        pos_d  = '0;
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                    if (i_q == {nrk_q, 2'b00} - IW'(1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, counters, status outputs and registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            nk_q    <= '0;
            nrk_q   <= '0;
            i_q     <= '0;
            wc_q    <= '0;
            pos_q   <= '0;
            rcon_q  <= '0;
            avail_q <= '0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            for (int unsigned j = 0; j < 8; j++)
                win_q[j] <= '0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            nrk_q   <= nrk_d;
            i_q     <= i_d;
            wc_q    <= wc_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            avail_q <= avail_d;
            done_q  <= done_d;
            rd_q    <= buf_q[rd_addr];
            for (int unsigned j = 0; j < 8; j++)
                win_q[j] <= win_d[j];
        end
    end

    // Round-key buffer: load-time words, then one generated word per cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_q[0] <= key[255:128];
            if (nk_in == 4'd6)
                buf_q[1][127:64] <= key[127:64];
            else if (nk_in == 4'd8)
                buf_q[1] <= key[127:0];
        end else if (gen_we) begin
            unique case (i_q[1:0])
                2'd0: buf_q[widx][127:96] <= new_w;
                2'd1: buf_q[widx][95:64]  <= new_w;
                2'd2: buf_q[widx][63:32]  <= new_w;
                default: buf_q[widx][31:0] <= new_w;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
`timescale 1ns/1ps
// Bench for aes_key_schedule: FIPS-197 key expansion model plus a cycle
// timeline of rk_avail/done/busy derived from the acceptance edge.
module tb_aes_key_schedule;
    localparam int unsigned RK_DEPTH = 16;
    localparam int unsigned AW       = 4;
    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_valid, key_ready, abort, busy, done;
    logic [255:0]  key;
    logic [1:0]    key_len;
    logic [AW:0]   num_rk, rk_avail;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data;

    always #5 clk = ~clk;

    aes_key_schedule #(.RK_DEPTH(RK_DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
        .key(key), .key_len(key_len), .num_rk(num_rk), .abort(abort),
        .busy(busy), .done(done), .rk_avail(rk_avail),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  sb [256];
    logic [31:0] mw [64];
    int mode = 0;   // 0 = no key, 1 = key accepted, 2 = aborted
    int mt, mnk, mn;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [7:0] r;
        r = v;
        for (int k = 0; k < s; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from the multiplicative inverse and the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k, input int nk, input int n);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*n; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic int avail_at(input int t);
        int w;
        if (t <= 0) return 0;
        w = mnk + t - 1;
        if (w > 4*mn) w = 4*mn;
        return w / 4;
    endfunction

    function automatic bit exp_busy();
        return mode == 1 && mt < 4*mn - mnk;
    endfunction

    function automatic int exp_avail();
        return (mode == 1) ? avail_at(mt) : 0;
    endfunction

    function automatic bit exp_done();
        return mode == 1 && mt >= 1 && avail_at(mt) == mn && avail_at(mt-1) != mn;
    endfunction

    // Compare process: inputs sampled at the falling edge, outputs checked 1 ns after the rising edge.
    initial begin : cmp
        logic          s_kv, s_ab, pre_busy;
        logic [AW-1:0] s_addr;
        logic [255:0]  s_key;
        logic [1:0]    s_len;
        logic [AW:0]   s_nrk;
        int            pre_avail, a, n;
        build_sbox();
        forever begin
            @(negedge clk);
            s_kv = key_valid; s_ab = abort; s_addr = rd_addr;
            s_key = key; s_len = key_len; s_nrk = num_rk;
            @(posedge clk);
            #1;
            pre_busy  = exp_busy();
            pre_avail = exp_avail();
            if (reset) begin
                mode = 0;
                chk("rd_data_reset", rd_data, 128'h0);
            end else begin
                a = int'(s_addr);
                if (mode == 1 && a < pre_avail)
                    chk("rd_data", rd_data, {mw[4*a], mw[4*a+1], mw[4*a+2], mw[4*a+3]});
                if (s_kv && !pre_busy) begin
                    mnk = (s_len == 2'd0) ? 4 : (s_len == 2'd1) ? 6 : 8;
                    n = int'(s_nrk);
                    mn = (n < 2) ? 2 : (n > int'(RK_DEPTH)) ? int'(RK_DEPTH) : n;
                    expand(s_key, mnk, mn);
                    mode = 1;
                    mt = 0;
                end else if (s_ab && pre_busy) begin
                    mode = 2;
                end else if (mode == 1) begin
                    mt++;
                end
            end
            chk("key_ready", key_ready, !exp_busy());
            chk("busy", busy, exp_busy());
            chk("done", done, exp_done());
            chk("rk_avail", rk_avail, exp_avail());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [255:0] k, input logic [1:0] len, input int n, input logic ab);
        key = k; key_len = len; num_rk = (AW+1)'(n); key_valid = 1'b1; abort = ab;
        @(posedge clk);
        #2;
        key_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget, input bit stream, output int lat);
        lat = start;
        forever begin
            @(posedge clk);
            lat++;
            #1;
            if (stream) rd_addr = (rk_avail == 0) ? '0 : AW'(rk_avail - 1);
            if (done) break;
            if (lat >= budget) begin
                chk("done_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    task automatic rd(input int a, output logic [127:0] d);
        rd_addr = AW'(a);
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : drv
        int           lat, cnt;
        logic [127:0] d, exp9;
        logic [31:0]  w;
        reset = 1'b1; key_valid = 1'b0; abort = 1'b0; key = '0; key_len = '0;
        num_rk = '0; rd_addr = '0;
        @(posedge clk); #1;
        chk("reset_ready", key_ready, 1'b1);
        chk("reset_avail", rk_avail, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // 128-bit, 11 keys, streaming reads of the newest key.
        send(KEY128, 2'd0, 11, 1'b0);
        wait_done(0, 80, 1'b1, lat);
        chk("a1_done_latency", lat, 41);
        rd(1, d);  chk("a1_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(10, d); chk("a1_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_a1_rk10", {mw[40], mw[41], mw[42], mw[43]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // 192-bit, 13 keys; a key offered while busy must be ignored.
        send(KEY192, 2'd1, 13, 1'b0);
        key = KEY128; key_len = 2'd0; key_valid = 1'b1;
        @(posedge clk); #2 key_valid = 1'b0; key = KEY192; key_len = 2'd1;
        wait_done(1, 80, 1'b0, lat);
        chk("a2_done_latency", lat, 47);
        rd(1, d); w = d[63:32]; chk("a2_w6", w, 32'hfe0c91f7);
        rd(12, d); chk("a2_rk12", d, 128'he98ba06f448c773c8ecc720401002202);
        chk("model_a2_w6", mw[6], 32'hfe0c91f7);

        // 256-bit, 15 keys, then 10 keys.
        send(KEY256, 2'd2, 15, 1'b0);
        wait_done(0, 80, 1'b0, lat);
        chk("a3_done_latency", lat, 53);
        rd(2, d); w = d[127:96]; chk("a3_w8", w, 32'h9ba35411);
        rd(14, d); chk("a3_rk14", d, 128'hfe4890d1e6188d0b046df344706c631e);
        chk("model_a3_w8", mw[8], 32'h9ba35411);
        exp9 = {mw[36], mw[37], mw[38], mw[39]};
        send(KEY256, 2'd2, 10, 1'b0);
        wait_done(0, 80, 1'b0, lat);
        chk("cn_done_latency", lat, 33);
        rd(9, d); chk("cn_rk9", d, exp9);

        // Abort sampled at the 5th GEN cycle.
        send(KEY128, 2'd0, 11, 1'b0);
        repeat (4) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready", key_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_avail", rk_avail, 0);
        cnt = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        // Key with abort in IDLE is accepted; 256-bit with 2 keys completes at load.
        send(KEY256, 2'd2, 2, 1'b1);
        chk("nrk2_busy", busy, 1'b0);
        wait_done(0, 10, 1'b0, lat);
        chk("nrk2_done_latency", lat, 1);
        chk("nrk2_avail", rk_avail, 2);
        rd(1, d); chk("nrk2_rk1", d, 128'h1f352c073b6108d72d9810a30914dff4);

        // num_rk = 0 clamps to 2; key_len = 3 behaves as 256-bit.
        repeat (2) @(posedge clk);
        #2;
        send(KEY256, 2'd3, 0, 1'b0);
        wait_done(0, 10, 1'b0, lat);
        chk("nrk0_done_latency", lat, 1);
        chk("nrk0_avail", rk_avail, 2);

        // num_rk above the depth clamps to 16 keys (Rcon beyond 0x36).
        repeat (2) @(posedge clk);
        #2;
        send(KEY128, 2'd0, 20, 1'b0);
        wait_done(0, 90, 1'b0, lat);
        chk("clamp_done_latency", lat, 61);
        chk("clamp_avail", rk_avail, 16);
        rd(15, d);

        // Asynchronous reset in the middle of GEN.
        send(KEY192, 2'd1, 13, 1'b0);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_avail", rk_avail, 0);
        chk("rst_rd_data", rd_data, 128'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
